// File: rtl/hazard_md_ctrl_if.sv
// hazard_md_ctrl_if
//   Groups the D/E/M hazard-detection inputs and the scheduler outputs of
//   hazard_md_ctrl into one bundle.
//   master modport : pipeline side (drives stage info, observes stall/md state)
//   slave  modport : hazard_md_ctrl itself
//   Signals:
//     D_rs_addr/D_rt_addr   register numbers read by the D-stage instruction
//     D_tuse_rs/D_tuse_rt   cycles until the operand is needed (3 = unused)
//     D_md                  D instruction needs the multiply/divide unit
//     E_wr_addr/E_tnew      E-stage destination and cycles until its result
//     M_wr_addr/M_tnew      M-stage destination and cycles until its result
//     E_md_start/E_md_div   E instruction starts md unit (div when E_md_div)
//     stall/flush_ex        freeze PC + IF/ID, bubble into ID/EX
//     md_busy/md_cnt        md unit occupied / remaining busy cycles
//     stall_count           saturating count of stalled cycles
//     md_state              debug view of the md FSM (0 = IDLE, 1 = BUSY)
//   No valid/ready handshake is involved: every input is sampled every
//   cycle, and stall/flush_ex respond combinationally in the same cycle.
interface hazard_md_ctrl_if #(
  parameter int CNT_W = 4
);
  logic [4:0]       D_rs_addr;
  logic [4:0]       D_rt_addr;
  logic [1:0]       D_tuse_rs;
  logic [1:0]       D_tuse_rt;
  logic             D_md;
  logic [4:0]       E_wr_addr;
  logic [1:0]       E_tnew;
  logic [4:0]       M_wr_addr;
  logic [1:0]       M_tnew;
  logic             E_md_start;
  logic             E_md_div;
  logic             stall;
  logic             flush_ex;
  logic             md_busy;
  logic [CNT_W-1:0] md_cnt;
  logic [31:0]      stall_count;
  logic             md_state;

  modport master (
    output D_rs_addr, D_rt_addr, D_tuse_rs, D_tuse_rt, D_md,
    output E_wr_addr, E_tnew, M_wr_addr, M_tnew, E_md_start, E_md_div,
    input  stall, flush_ex, md_busy, md_cnt, stall_count, md_state
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_tuse_rs, D_tuse_rt, D_md,
    input  E_wr_addr, E_tnew, M_wr_addr, M_tnew, E_md_start, E_md_div,
    output stall, flush_ex, md_busy, md_cnt, stall_count, md_state
  );
endinterface

// File: rtl/hazard_md_ctrl.sv
// hazard_md_ctrl
//   Hazard and multiply/divide scheduler for the 5-stage MIPS pipeline.
//   Each cycle decides whether the D-stage instruction may advance; on a
//   stall the PC and IF/ID hold and ID/EX is cleared so a bubble enters E.
//   A two-state FSM with a down-counter tracks md unit occupancy, and a
//   saturating counter records the number of stalled cycles.
//   Ports:
//     clk    rising-edge system clock
//     reset  asynchronous, active-low reset
//     bus    hazard_md_ctrl_if slave modport (stage info in, stall/md out)
module hazard_md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic             clk,
  input logic             reset,
  hazard_md_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q;

  logic rs_hazard;
  logic rt_hazard;
  logic md_hazard;
  logic stall_int;

  // A source operand is hazardous when a younger-than-needed producer in E
  // or M writes it. Register 0 is hard-wired, and Tnew 0 means the value is
  // already forwardable, which the unsigned '>' excludes automatically.
  always_comb begin
    rs_hazard = 1'b0;
    rt_hazard = 1'b0;
    if (bus.D_rs_addr != 5'd0) begin
      rs_hazard = ((bus.E_wr_addr == bus.D_rs_addr) && (bus.E_tnew > bus.D_tuse_rs)) ||
                  ((bus.M_wr_addr == bus.D_rs_addr) && (bus.M_tnew > bus.D_tuse_rs));
    end
    if (bus.D_rt_addr != 5'd0) begin
      rt_hazard = ((bus.E_wr_addr == bus.D_rt_addr) && (bus.E_tnew > bus.D_tuse_rt)) ||
                  ((bus.M_wr_addr == bus.D_rt_addr) && (bus.M_tnew > bus.D_tuse_rt));
    end
  end

  // An md instruction in D must wait while the unit is occupied, including
  // the cycle in which E is starting it (busy only shows up one cycle later).
  assign md_hazard = bus.D_md && (bus.E_md_start || (state_q == BUSY));
  assign stall_int = rs_hazard || rt_hazard || md_hazard;

  assign bus.stall    = stall_int;
  assign bus.flush_ex = stall_int;
  assign bus.md_busy  = (state_q == BUSY);
  assign bus.md_cnt   = cnt_q;
  assign bus.md_state = state_q;
  assign bus.stall_count = stall_cnt_q;

  // md FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // md FSM next state. Independent of stall: the E instruction has already
  // issued, so its busy period always runs to completion. A start seen while
  // BUSY is ignored rather than reloading the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.E_md_start) begin
          state_d = BUSY;
          cnt_d   = bus.E_md_div ? DIV_LOAD : MULT_LOAD;
        end else begin
          cnt_d = '0;
        end
      end
      BUSY: begin
        // '<=' also recovers from a zero count that cannot occur normally.
        if (cnt_q <= CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stalled-cycle counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall_int && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_md_ctrl.sv
module tb_hazard_md_ctrl;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = 4;
  localparam int W           = 3 + CNT_W + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_md_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_md_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: the md unit is described by the last cycle in which it
  // is still busy; the stall counter is an unbounded integer clipped to 32 bits.
  longint cyc      = 0;
  longint busy_end = -1;
  longint sc       = 0;

  // Largest number of cycles D would have to wait for this operand.
  function automatic int wait_for(input logic [4:0] addr, input logic [1:0] tuse);
    int w;
    w = 0;
    if (addr == 5'd0) return 0;
    if (bus.E_wr_addr == addr && (int'(bus.E_tnew) - int'(tuse)) > w)
      w = int'(bus.E_tnew) - int'(tuse);
    if (bus.M_wr_addr == addr && (int'(bus.M_tnew) - int'(tuse)) > w)
      w = int'(bus.M_tnew) - int'(tuse);
    return w;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rst_v,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] tus, input logic [1:0] tut,
                      input logic dmd,
                      input logic [4:0] ew, input logic [1:0] etn,
                      input logic [4:0] mw, input logic [1:0] mtn,
                      input logic st, input logic dv);
    logic busy, stl;
    logic [CNT_W-1:0] cnt;
    @(posedge clk);
    #1;
    reset          = rst_v;
    bus.D_rs_addr  = rs;
    bus.D_rt_addr  = rt;
    bus.D_tuse_rs  = tus;
    bus.D_tuse_rt  = tut;
    bus.D_md       = dmd;
    bus.E_wr_addr  = ew;
    bus.E_tnew     = etn;
    bus.M_wr_addr  = mw;
    bus.M_tnew     = mtn;
    bus.E_md_start = st;
    bus.E_md_div   = dv;
    if (!rst_v) begin
      busy_end = -1;
      sc       = 0;
    end
    busy = (cyc <= busy_end);
    cnt  = busy ? CNT_W'(busy_end - cyc + 1) : '0;
    stl  = (wait_for(rs, tus) > 0) || (wait_for(rt, tut) > 0) || (dmd && (st || busy));
    exp_q.push_back({stl, stl, busy, cnt, sc[31:0]});
    // advance the model across the coming clock edge
    if (rst_v) begin
      if (stl && sc < 64'hFFFF_FFFF) sc = sc + 1;
      if (st && !busy) busy_end = cyc + (dv ? DIV_CYCLES : MULT_CYCLES);
    end
    cyc = cyc + 1;
  endtask

  task automatic quiet(input logic dmd);
    step(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, dmd, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic md_start(input logic dmd, input logic dv);
    step(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, dmd, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, dv);
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      failures = failures + 1;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall",       32'(bus.stall),       32'(e[W-1]));
      check("flush_ex",    32'(bus.flush_ex),    32'(e[W-2]));
      check("md_busy",     32'(bus.md_busy),     32'(e[W-3]));
      check("md_cnt",      32'(bus.md_cnt),      32'(e[32 +: CNT_W]));
      check("stall_count", bus.stall_count,      e[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.D_rs_addr = '0; bus.D_rt_addr = '0; bus.D_tuse_rs = 2'd3; bus.D_tuse_rt = 2'd3;
    bus.D_md = 1'b0; bus.E_wr_addr = '0; bus.E_tnew = '0; bus.M_wr_addr = '0;
    bus.M_tnew = '0; bus.E_md_start = 1'b0; bus.E_md_div = 1'b0;

    // reset held for two cycles
    step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    quiet(1'b0);

    // load-use on rs, then the same producer one cycle later
    step(1'b1, 5'd8, 5'd0, 2'd0, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 5'd8, 5'd0, 2'd0, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 5'd8, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);

    // register 0 never stalls; M-stage match on rt does
    step(1'b1, 5'd0, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd9, 2'd3, 2'd0, 1'b0, 5'd0, 2'd0, 5'd9, 2'd1, 1'b0, 1'b0);
    // Tnew 0 never stalls
    step(1'b1, 5'd4, 5'd4, 2'd0, 2'd0, 1'b0, 5'd4, 2'd0, 5'd4, 2'd0, 1'b0, 1'b0);

    // mult with D_md held: stall from start cycle through last busy cycle
    md_start(1'b1, 1'b0);
    repeat (MULT_CYCLES + 2) quiet(1'b1);

    // div with a second start mid-busy (must not reload)
    md_start(1'b0, 1'b1);
    repeat (3) quiet(1'b0);
    md_start(1'b0, 1'b0);
    repeat (DIV_CYCLES) quiet(1'b0);

    // async reset mid-div, asserted between edges
    md_start(1'b0, 1'b1);
    repeat (4) quiet(1'b0);
    step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    quiet(1'b1);
    quiet(1'b1);

    // randomized traffic, small register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      step(1'b1,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0),
           5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
    repeat (DIV_CYCLES + 1) quiet(1'b0);

    // saturation: preload the counter just below the top
    quiet(1'b0);
    @(negedge clk);
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    sc = 64'hFFFF_FFFE;
    repeat (4) step(1'b1, 5'd8, 5'd0, 2'd0, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    quiet(1'b0);

    repeat (2) @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_md_ctrl.md
Name: hazard_md_ctrl

Overview:
Pipeline hazard and multiply/divide scheduler for the 5-stage MIPS core. Decides each cycle whether the D-stage instruction may advance. On a stall it freezes PC and IF/ID, and drives the ID/EX clear input (stop_sel) so a bubble enters E. Tracks the occupancy of the shared multiply/divide unit with a busy FSM and down-counter, and keeps a saturating stall-cycle counter for performance checks.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start (>=1)
DIV_CYCLES, 10, busy cycles after a div/divu start (>=1)
CNT_W, 4, md counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
D_rs_addr  input  5  rs register number of D-stage instruction
D_rt_addr  input  5  rt register number of D-stage instruction
D_tuse_rs  input  2  cycles until rs is needed (3 = not used)
D_tuse_rt  input  2  cycles until rt is needed (3 = not used)
D_md  input  1  D instruction uses md unit (mult/div/mfhi/mflo/mthi/mtlo)
E_wr_addr  input  5  destination register of E-stage instruction (0 = none)
E_tnew  input  2  cycles until E result is available
M_wr_addr  input  5  destination register of M-stage instruction (0 = none)
M_tnew  input  2  cycles until M result is available
E_md_start  input  1  E-stage instruction starts md unit this cycle
E_md_div  input  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu
stall  output  1  1 = hold PC and IF/ID
flush_ex  output  1  to ID/EX stop_sel; equals stall
md_busy  output  1  md unit occupied
md_cnt  output  CNT_W  remaining md busy cycles
stall_count  output  32  total stalled cycles since reset

Behaviour:
- Reset (reset=0, asynchronous): FSM -> IDLE, md_cnt=0, md_busy=0, stall_count=0. Held for as long as reset=0. An operation in progress is aborted.
- stall and flush_ex are combinational, valid in the same cycle as the inputs.
- rs hazard:
  - D_rs_addr != 0 and either (E_wr_addr==D_rs_addr and E_tnew > D_tuse_rs) or (M_wr_addr==D_rs_addr and M_tnew > D_tuse_rs).
  - Compares are unsigned.
- rt hazard: same as rs hazard, using D_rt_addr and D_tuse_rt.
- md hazard: D_md and (E_md_start or md_busy).
- stall = rs hazard | rt hazard | md hazard. flush_ex = stall.
- Register 0 never causes a hazard. Tnew 0 never causes a hazard.
- FSM states: IDLE and BUSY. md_busy = (state == BUSY).
  - IDLE, E_md_start=1: go to BUSY; md_cnt <= E_md_div ? DIV_CYCLES : MULT_CYCLES.
  - IDLE, E_md_start=0: stay IDLE, md_cnt = 0.
  - BUSY: md_cnt decrements by 1 each cycle. When md_cnt==1, next state is IDLE and md_cnt becomes 0.
  - E_md_start in BUSY is ignored: no restart and no error. md hazard stalls prevent it in legal flows.
- Timing: a mult started in cycle t gives md_busy=1 in cycles t+1 .. t+MULT_CYCLES, and 0 at t+MULT_CYCLES+1. A div behaves the same with DIV_CYCLES.
- The md FSM does not depend on stall. The E-stage instruction has already issued, so it always completes its busy period.
- stall_count: +1 on each rising edge where stall=1; saturates at 0xFFFFFFFF with no wrap.
- Simultaneous hazards: stall is a single OR; stall_count advances by only 1 per cycle.

Test Plan:
- Load-use: E_wr_addr=8, E_tnew=2, D_rs_addr=8, D_tuse_rs=0 -> stall=1, flush_ex=1, stall_count increments. Change E_tnew to 1 with D_tuse_rs=1 -> stall=0.
- Zero register: E_wr_addr=0, E_tnew=2, D_rs_addr=0, D_tuse_rs=0 -> stall=0. M-stage match M_wr_addr=9, M_tnew=1, D_rt_addr=9, D_tuse_rt=0 -> stall=1.
- Mult: pulse E_md_start=1, E_md_div=0 for one cycle -> md_cnt reads 5,4,3,2,1 over the next 5 cycles, then 0 with md_busy=0. With D_md=1 held throughout -> stall=1 from the start cycle through the last busy cycle (6 cycles).
- Div: E_md_div=1 -> md_busy=1 for exactly 10 cycles. A second E_md_start pulse mid-busy -> md_cnt is not reloaded.
- Async reset: assert reset=0 mid-div with md_cnt=6, between clock edges -> md_busy=0, md_cnt=0, stall_count=0 immediately. After release, D_md=1 alone gives stall=0.
- Saturation: force stall_count near the top (0xFFFFFFFE via a long stall or a force) and hold stall=1 for 3 cycles -> 0xFFFFFFFF, no wrap.
